// File: rtl/ntt_addr_gen_pkg.sv
// Shared constants and FSM encoding for the multilane NTT address generator.
// P butterflies per beat over 2P banks; MAP = log2(2P) bits of bank index per lane.
package ntt_addr_gen_pkg;

  localparam int P       = 2;
  localparam int MAP     = 2;
  localparam int L       = 1;
  localparam int LANES   = 2 * P;
  localparam int BI_PACK = LANES * MAP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ntt_addr_gen_bank_map.sv
// Coefficient index to {bank index, in-bank address} map for one lane.
// The bank index is the digit sum (MAP-bit digits) of j, wrapping mod 2P.
module bank_map
  import ntt_addr_gen_pkg::*;
#(
  parameter int N_LOG  = 8,
  parameter int ADDR_W = N_LOG - MAP
) (
  input  logic [N_LOG-1:0]  j,
  output logic [MAP-1:0]    bi,
  output logic [ADDR_W-1:0] addr
);

  localparam int NDIG = (N_LOG + MAP - 1) / MAP;

  logic [NDIG*MAP-1:0] j_pad_s;
  logic [MAP-1:0]      sum_s;

  // Digit sum; the MAP-bit accumulator wraps, which is exactly mod 2P.
  always_comb begin
    j_pad_s = '0;
    j_pad_s[N_LOG-1:0] = j;
    sum_s = '0;
    for (int d = 0; d < NDIG; d++) begin
      sum_s = sum_s + j_pad_s[d*MAP +: MAP];
    end
  end

  assign bi   = sum_s;
  assign addr = ADDR_W'(j >> MAP);

endmodule

// File: rtl/ntt_addr_gen.sv
// Radix-2 NTT stage/iteration walker emitting per-lane bank indices and addresses.
// Optional inverse (Gentleman-Sande) ordering is enabled by NTT_ADDR_INV_EN.
module ntt_addr_gen
  import ntt_addr_gen_pkg::*;
#(
  parameter int N_LOG     = 8,
  parameter int STAGE_GAP = L + 2,
  parameter int ADDR_W    = N_LOG - MAP,
  localparam int SW       = cnt_width(N_LOG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
`ifdef NTT_ADDR_INV_EN
  input  logic                    inv,
`endif
  output logic [BI_PACK-1:0]      BI_bus,
  output logic [LANES*ADDR_W-1:0] addr_bus,
  output logic [SW-1:0]           stage,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int KW = N_LOG - MAP;
  localparam int GW = cnt_width(STAGE_GAP);
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG - 1);
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [GW-1:0] G_LAST = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  state_t            state_r;
  logic [SW-1:0]     s_r;
  logic [KW-1:0]     k_r;
  logic [GW-1:0]     gap_r;
  logic              inv_sel_s;

  logic [SW:0]       h_s;
  logic [N_LOG-1:0]  g_s      [P];
  logic [N_LOG-1:0]  j_s      [LANES];
  logic [MAP-1:0]    bi_s     [LANES];
  logic [ADDR_W-1:0] addr_s   [LANES];
  logic [BI_PACK-1:0]      bi_pack_s;
  logic [LANES*ADDR_W-1:0] addr_pack_s;

`ifdef NTT_ADDR_INV_EN
  logic inv_r;

  // Ordering select is captured with an accepted start and held for the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_r <= 1'b0;
    end else if (!stall && state_r == IDLE && start) begin
      inv_r <= inv;
    end else begin
      inv_r <= inv_r;
    end
  end

  assign inv_sel_s = inv_r;
`else
  assign inv_sel_s = 1'b0;
`endif

  // Lower index of the butterfly pair: insert a zero at bit h of g.
  function automatic logic [N_LOG-1:0] low_index(input logic [N_LOG-1:0] g,
                                                 input logic [SW:0]      h);
    logic [N_LOG-1:0] mask;
    mask = (N_LOG'(1'b1) << h) - N_LOG'(1'b1);
    return ((g >> h) << (h + 1'b1)) | (g & mask);
  endfunction

  // Pair-index generation for the current (stage, iteration).
  always_comb begin
    if (inv_sel_s) begin
      h_s = {1'b0, s_r};
    end else begin
      h_s = (SW + 1)'(N_LOG - 1) - {1'b0, s_r};
    end
    for (int b = 0; b < P; b++) begin
      g_s[b]       = N_LOG'(k_r) * N_LOG'(P) + N_LOG'(b);
      j_s[2*b]     = low_index(g_s[b], h_s);
      j_s[2*b + 1] = low_index(g_s[b], h_s) | (N_LOG'(1'b1) << h_s);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bank_map #(
      .N_LOG  (N_LOG),
      .ADDR_W (ADDR_W)
    ) u_map (
      .j    (j_s[i]),
      .bi   (bi_s[i]),
      .addr (addr_s[i])
    );
  end

  // Lane packing: lane i occupies slice i of each bus.
  always_comb begin
    bi_pack_s   = '0;
    addr_pack_s = '0;
    for (int i = 0; i < LANES; i++) begin
      bi_pack_s[i*MAP +: MAP]      = bi_s[i];
      addr_pack_s[i*ADDR_W +: ADDR_W] = addr_s[i];
    end
  end

  // Transform sequencer: FSM, counters and registered output buses; stall freezes all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      s_r      <= '0;
      k_r      <= '0;
      gap_r    <= '0;
      BI_bus   <= '0;
      addr_bus <= '0;
      stage    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (!stall) begin
      case (state_r)
        IDLE: begin
          valid <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state_r <= RUN;
            busy    <= 1'b1;
            s_r     <= '0;
            k_r     <= '0;
          end
        end
        RUN: begin
          valid    <= 1'b1;
          BI_bus   <= bi_pack_s;
          addr_bus <= addr_pack_s;
          stage    <= s_r;
          if (k_r == K_LAST) begin
            k_r <= '0;
            if (s_r == S_LAST) begin
              state_r <= FIN;
            end else begin
              s_r     <= s_r + 1'b1;
              gap_r   <= '0;
              state_r <= (STAGE_GAP > 0) ? GAP : RUN;
            end
          end else begin
            k_r <= k_r + 1'b1;
          end
        end
        GAP: begin
          valid <= 1'b0;
          if (gap_r == G_LAST) begin
            state_r <= RUN;
          end else begin
            gap_r <= gap_r + 1'b1;
          end
        end
        FIN: begin
          valid   <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed bench for ntt_addr_gen with P=2, MAP=2, N_LOG=4, STAGE_GAP=3.
`timescale 1ns/1ps
module tb_ntt_addr_gen;

  localparam int N_LOG     = 4;
  localparam int STAGE_GAP = 3;
  localparam int NBEAT     = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
`ifdef NTT_ADDR_INV_EN
  logic       inv;
`endif
  logic [7:0] BI_bus;
  logic [7:0] addr_bus;
  logic [1:0] stage;
  logic       valid;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  logic [7:0] cap_bi [NBEAT+8];
  logic [7:0] cap_ad [NBEAT+8];
  int         cap_st [NBEAT+8];

  typedef struct packed {
    logic [7:0] beat;
    logic [7:0] bi;
    logic [7:0] ad;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  ntt_addr_gen #(
    .N_LOG     (N_LOG),
    .STAGE_GAP (STAGE_GAP),
    .ADDR_W    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
`ifdef NTT_ADDR_INV_EN
    .inv      (inv),
`endif
    .BI_bus   (BI_bus),
    .addr_bus (addr_bus),
    .stage    (stage),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pk(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  // Reference beat: the g-th index with bit h clear pairs with that index plus 2^h.
  function automatic logic [15:0] model_beat(input int s, input int k, input bit iv);
    int h, g, j, cnt;
    int lanes [4];
    logic [7:0] bi8, ad8;
    h = iv ? s : N_LOG - 1 - s;
    for (int b = 0; b < 2; b++) begin
      g = k * 2 + b;
      cnt = 0;
      j = 0;
      for (int x = 0; x < 16; x++) begin
        if (((x >> h) & 1) == 0) begin
          if (cnt == g) j = x;
          cnt++;
        end
      end
      lanes[2*b]     = j;
      lanes[2*b + 1] = j + (1 << h);
    end
    for (int i = 0; i < 4; i++) begin
      bi8[2*i +: 2] = 2'(((lanes[i] % 4) + (lanes[i] / 4)) % 4);
      ad8[2*i +: 2] = 2'(lanes[i] / 4);
    end
    return {ad8, bi8};
  endfunction

  task automatic verify_run(input bit iv);
    logic [15:0] m;
    for (int i = 0; i < NBEAT; i++) begin
      m = model_beat(i / 4, i % 4, iv);
      chk($sformatf("beat%0d_bi", i), cap_bi[i], m[7:0]);
      chk($sformatf("beat%0d_addr", i), cap_ad[i], m[15:8]);
      chk($sformatf("beat%0d_stage", i), cap_st[i], i / 4);
      chk($sformatf("beat%0d_pair0_distinct", i), cap_bi[i][1:0] != cap_bi[i][3:2], 1);
      chk($sformatf("beat%0d_pair1_distinct", i), cap_bi[i][5:4] != cap_bi[i][7:6], 1);
    end
  endtask

  // Launch a transform and observe it to done; optional stall and start-while-busy.
  task automatic run_once(input bit iv, input int stall_at, input int restart_at);
    int nbeats, gap_len, ngaps, ndone, first_cyc, stall_left;
    bit fin, stall_used, restart_used, was_stalled;
    logic [7:0] snap_bi, snap_ad;
    logic [1:0] snap_st;
    logic       snap_v;
    nbeats = 0; gap_len = 0; ngaps = 0; ndone = 0; first_cyc = -1; stall_left = 0;
    fin = 1'b0; stall_used = 1'b0; restart_used = 1'b0;
    snap_bi = '0; snap_ad = '0; snap_st = '0; snap_v = 1'b0;
`ifdef NTT_ADDR_INV_EN
    inv = iv;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef NTT_ADDR_INV_EN
    inv = ~iv;
`endif
    chk("start_busy", busy, 1);
    chk("start_valid", valid, 0);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      was_stalled = stall;
      @(posedge clk); #1;
      if (was_stalled) begin
        chk("stall_freeze_bi", BI_bus, snap_bi);
        chk("stall_freeze_addr", addr_bus, snap_ad);
        chk("stall_freeze_stage", stage, snap_st);
        chk("stall_freeze_valid", valid, snap_v);
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end else begin
        start = 1'b0;
        if (done) begin
          ndone++;
          chk("done_busy_low", busy, 0);
          chk("done_valid_low", valid, 0);
          fin = 1'b1;
        end else if (valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (gap_len > 0) begin
            chk("gap_len", gap_len, STAGE_GAP);
            ngaps++;
            gap_len = 0;
          end
          if (nbeats < NBEAT + 8) begin
            cap_bi[nbeats] = BI_bus;
            cap_ad[nbeats] = addr_bus;
            cap_st[nbeats] = int'(stage);
          end
          nbeats++;
        end else if (busy) begin
          gap_len++;
        end else begin
          chk("busy_dropped_without_done", done, 1);
          fin = 1'b1;
        end
        if (!fin && stall_at >= 0 && !stall_used && nbeats == stall_at) begin
          stall = 1'b1; stall_left = 5; stall_used = 1'b1;
          snap_bi = BI_bus; snap_ad = addr_bus; snap_st = stage; snap_v = valid;
        end
        if (!fin && restart_at >= 0 && !restart_used && nbeats == restart_at) begin
          start = 1'b1;
          restart_used = 1'b1;
        end
      end
    end
    start = 1'b0;
    stall = 1'b0;
    chk("run_completed", fin, 1);
    chk("beat_count", nbeats, NBEAT);
    chk("gap_count", ngaps, N_LOG - 1);
    chk("done_count", ndone, 1);
    chk("first_beat_latency", first_cyc, 0);
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Hand-computed beats: {beat index, BI lanes 0..3, addr lanes 0..3}
    vecs[0] = '{beat: 8'd0,  bi: pk(0, 2, 1, 3), ad: pk(0, 2, 0, 2)};
    vecs[1] = '{beat: 8'd1,  bi: pk(2, 0, 3, 1), ad: pk(0, 2, 0, 2)};
    vecs[2] = '{beat: 8'd3,  bi: pk(3, 1, 0, 2), ad: pk(1, 3, 1, 3)};
    vecs[3] = '{beat: 8'd4,  bi: pk(0, 1, 1, 2), ad: pk(0, 1, 0, 1)};
    vecs[4] = '{beat: 8'd6,  bi: pk(2, 3, 3, 0), ad: pk(2, 3, 2, 3)};
    vecs[5] = '{beat: 8'd9,  bi: pk(1, 3, 2, 0), ad: pk(1, 1, 1, 1)};
    vecs[6] = '{beat: 8'd12, bi: pk(0, 1, 2, 3), ad: pk(0, 0, 0, 0)};
    vecs[7] = '{beat: 8'd15, bi: pk(3, 0, 1, 2), ad: pk(3, 3, 3, 3)};

    rst = 1'b0; start = 1'b0; stall = 1'b0;
`ifdef NTT_ADDR_INV_EN
    inv = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bi", BI_bus, 0);
    chk("reset_addr", addr_bus, 0);
    chk("reset_stage", stage, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Forward run with a start pulse while busy that must be ignored.
    run_once(1'b0, -1, 8);
    verify_run(1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_bi", i), cap_bi[vecs[i].beat], vecs[i].bi);
      chk($sformatf("vec%0d_addr", i), cap_ad[vecs[i].beat], vecs[i].ad);
    end

    // Five-cycle stall in the middle of stage 1.
    run_once(1'b0, 5, -1);
    verify_run(1'b0);

    // Reset in the middle of a run, then a clean transform.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_busy_before_reset", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrun_reset_bi", BI_bus, 0);
    chk("midrun_reset_addr", addr_bus, 0);
    chk("midrun_reset_stage", stage, 0);
    chk("midrun_reset_valid", valid, 0);
    chk("midrun_reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post_reset_no_done", done, 0);
      chk("post_reset_idle", busy, 0);
    end
    run_once(1'b0, -1, -1);
    verify_run(1'b0);

`ifdef NTT_ADDR_INV_EN
    run_once(1'b1, -1, -1);
    verify_run(1'b1);
    chk("inv_first_bi", cap_bi[0], pk(0, 1, 2, 3));
    chk("inv_first_addr", cap_ad[0], pk(0, 0, 0, 0));
    chk("inv_last_stage_bi", cap_bi[12], pk(0, 2, 1, 3));
    chk("inv_last_stage_addr", cap_ad[12], pk(0, 2, 0, 2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
